// File: rtl/kernel_run_ctrl_pkg.sv
// kernel_run_ctrl_pkg: shared state encoding and width helper
// for the ap_ctrl_hs run sequencer and its watchdog.
package kernel_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FILL = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_CHECK     = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  // Ceil-log2 width, never below one bit.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/kernel_run_ctrl_run_watchdog.sv
// run_watchdog: cycle counter cleared on START entry, counting
// while enabled; expired is high on its final count.
module run_watchdog
  import kernel_run_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = clog2w(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/kernel_run_ctrl.sv
// kernel_run_ctrl: gates ap_start on RAM refill, counts runs,
// rotates datasets, checks output count/signature, watchdogs done.
// Ports: ap_clk/ap_rst, run_en, refill_busy, k_ap_* handshake,
// y_out_* stream in; dataset_idx, run_cnt, sig_*, err_*, busy,
// all_done out.
module kernel_run_ctrl
  import kernel_run_ctrl_pkg::*;
#(
  parameter int DATASET_NUM    = 8,
  parameter int RAM_UPDATE_INV = 1,
  parameter int OUT_PER_RUN    = 64,
  parameter int NUM_RUNS       = 0,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int DW = clog2w(DATASET_NUM)
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          run_en,
  input  logic          refill_busy,
  output logic          k_ap_start,
  input  logic          k_ap_ready,
  input  logic          k_ap_done,
  input  logic          y_out_write,
  input  logic [31:0]   y_out_din,
  output logic [DW-1:0] dataset_idx,
  output logic [31:0]   run_cnt,
  output logic [31:0]   sig_out,
  output logic          sig_valid,
  output logic          err_count,
  output logic          err_timeout,
  output logic          busy,
  output logic          all_done
);

  localparam int CW = clog2w(OUT_PER_RUN + 2);
  localparam int IW = clog2w(RAM_UPDATE_INV);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_EXP = CW'(OUT_PER_RUN);
  localparam logic [IW-1:0] INV_LAST = IW'(RAM_UPDATE_INV - 1);
  localparam logic [DW-1:0] DS_LAST = DW'(DATASET_NUM - 1);

  state_e state, state_nxt;

  logic [CW-1:0] out_cnt;
  logic [IW-1:0] inv_cnt;
  logic [31:0]   acc;
  logic [31:0]   sig_last;
  logic [31:0]   run_cnt_nxt;
  logic          acc_en;
  logic          last_run;
  logic          wd_clr;
  logic          wd_exp;

  assign acc_en      = (state == S_START) || (state == S_RUN);
  assign run_cnt_nxt = run_cnt + 32'd1;
  assign last_run    = (NUM_RUNS != 0) &&
                       (run_cnt_nxt == 32'(NUM_RUNS));
  assign wd_clr      = (state_nxt == S_START) &&
                       (state != S_START);

  run_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .clr    (wd_clr),
    .en     (acc_en),
    .expired(wd_exp)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // done is tested ahead of the watchdog so it wins a tie.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (run_en)
          state_nxt = refill_busy ? S_WAIT_FILL : S_START;
      S_WAIT_FILL:
        if (!refill_busy)
          state_nxt = S_START;
      S_START:
        if (k_ap_done)
          state_nxt = S_CHECK;
        else if (wd_exp)
          state_nxt = S_HALT;
        else if (k_ap_ready)
          state_nxt = S_RUN;
      S_RUN:
        if (k_ap_done)
          state_nxt = S_CHECK;
        else if (wd_exp)
          state_nxt = S_HALT;
      S_CHECK:
        if (last_run)
          state_nxt = S_HALT;
        else if (run_en)
          state_nxt = refill_busy ? S_WAIT_FILL : S_START;
        else
          state_nxt = S_IDLE;
      S_HALT:
        state_nxt = S_HALT;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    k_ap_start = (state == S_START);
    sig_valid  = (state == S_CHECK);
    sig_out    = sig_valid ? acc : sig_last;
    busy       = (state != S_IDLE) && (state != S_HALT);
    all_done   = (state == S_HALT);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc         <= '0;
      out_cnt     <= '0;
      sig_last    <= '0;
      run_cnt     <= '0;
      inv_cnt     <= '0;
      dataset_idx <= '0;
      err_count   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (y_out_write) begin
        if (acc_en) begin
          acc <= acc ^ y_out_din;
          if (out_cnt != CNT_MAX)
            out_cnt <= out_cnt + 1'b1;
        end else begin
          err_count <= 1'b1;
        end
      end
      if (wd_exp && !k_ap_done)
        err_timeout <= 1'b1;
      if (state == S_CHECK) begin
        acc      <= '0;
        out_cnt  <= '0;
        sig_last <= acc;
        run_cnt  <= run_cnt_nxt;
        if (out_cnt != CNT_EXP)
          err_count <= 1'b1;
        // inv_cnt tracks run_cnt mod RAM_UPDATE_INV.
        if (inv_cnt == INV_LAST) begin
          inv_cnt <= '0;
          if (dataset_idx == DS_LAST)
            dataset_idx <= '0;
          else
            dataset_idx <= dataset_idx + 1'b1;
        end else begin
          inv_cnt <= inv_cnt + 1'b1;
        end
      end
    end
  end

endmodule
